// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared types and constants for the 4-digit 7-segment scan controller.
//   state_t   : scan FSM state (blank interval / digit lit)
//   an_t      : anode vector, active-low, one bit per digit
//   seg_t     : segment vector, active-low, bit6 = a ... bit0 = g
//   an_sel()  : one-hot-low anode pattern for a digit index
// ---------------------------------------------------------------------------
package seg7_pkg;

    typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

    localparam int NUM_DIGITS = 4;
    localparam int AN_W       = 4;
    localparam int SEG_W      = 7;

    typedef logic [AN_W-1:0]  an_t;
    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam an_t  AN_OFF    = 4'b1111;

    // One-hot-low anode pattern for the selected digit.
    function automatic an_t an_sel(input logic [1:0] idx);
        an_t res;
        case (idx)
            2'd0:    res = 4'b1110;
            2'd1:    res = 4'b1101;
            2'd2:    res = 4'b1011;
            2'd3:    res = 4'b0111;
            default: res = 4'b1111;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_bcd27seg.sv
// ---------------------------------------------------------------------------
// BCD27seg
// Combinational BCD to active-low 7-segment decoder (bit6 = a ... bit0 = g).
// Codes 10..15 produce an all-off pattern, so 4'hF is used as "blank".
//   bcd : 4-bit BCD code in
//   seg : active-low segment pattern out
// ---------------------------------------------------------------------------
module BCD27seg
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output seg_t       seg
);

    // Segment lookup table.
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment
// display. One shared decoder, a blank interval before each lit slot against
// ghosting, and double-buffered digit values swapped only at frame boundaries.
//
// Optional build macro: SEG7_LZB_EN enables leading-zero blanking of digits
// 3..1 (anode still driven, segments off). Scan timing is unaffected.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   en_i              : scan enable (0 = blank display, counters held at 0)
//   load_i            : one-cycle strobe capturing x0_i..x3_i
//   x0_i..x3_i        : BCD digits, x0 is rightmost
//   an_o              : anodes, active-low, one-hot-low
//   seg_o             : segments, active-low, bit6 = a ... bit0 = g
//   pending_o         : shadow holds values not yet displayed
//   frame_o           : one-cycle pulse after each frame boundary
// ---------------------------------------------------------------------------
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int CLK_DIV     = 50000,
    parameter int BLANK_TICKS = 1,
    parameter int SHOW_TICKS  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic       load_i,
    input  logic [3:0] x0_i,
    input  logic [3:0] x1_i,
    input  logic [3:0] x2_i,
    input  logic [3:0] x3_i,
    output logic [3:0] an_o,
    output logic [6:0] seg_o,
    output logic       pending_o,
    output logic       frame_o
);

    localparam int DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int SLOT_MAX = (BLANK_TICKS > SHOW_TICKS) ? BLANK_TICKS : SHOW_TICKS;
    localparam int SLOT_W   = (SLOT_MAX > 2) ? $clog2(SLOT_MAX) : 1;

    state_t            state_r;
    logic [1:0]        digit_r;
    logic [DIV_W-1:0]  div_cnt_r;
    logic [SLOT_W-1:0] slot_cnt_r;
    an_t               an_r;
    seg_t              seg_r;
    logic              pending_r;
    logic              frame_r;
    logic [3:0]        shadow_r  [NUM_DIGITS];
    logic [3:0]        display_r [NUM_DIGITS];

    logic [3:0]        x_s [NUM_DIGITS];
    logic              tick_s;
    logic              lz_s;
    logic [3:0]        dec_in_s;
    seg_t              dec_out_s;

    assign x_s[0] = x0_i;
    assign x_s[1] = x1_i;
    assign x_s[2] = x2_i;
    assign x_s[3] = x3_i;

    assign tick_s = (div_cnt_r == DIV_W'(CLK_DIV - 1));

    // Select the decoder input, forcing 4'hF for suppressed leading zeros.
    always_comb begin
        lz_s     = 1'b0;
        dec_in_s = display_r[digit_r];
`ifdef SEG7_LZB_EN
        case (digit_r)
            2'd3:    lz_s = (display_r[3] == 4'd0);
            2'd2:    lz_s = (display_r[3] == 4'd0) && (display_r[2] == 4'd0);
            2'd1:    lz_s = (display_r[3] == 4'd0) && (display_r[2] == 4'd0) &&
                            (display_r[1] == 4'd0);
            default: lz_s = 1'b0;
        endcase
`else
        lz_s = 1'b0;
`endif
        if (lz_s) begin
            dec_in_s = 4'hF;
        end else begin
            dec_in_s = display_r[digit_r];
        end
    end

    BCD27seg u_dec (
        .bcd (dec_in_s),
        .seg (dec_out_s)
    );

    // Tick divider, scan FSM, registered outputs and shadow/display buffering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_BLANK;
            digit_r    <= 2'd0;
            div_cnt_r  <= '0;
            slot_cnt_r <= '0;
            an_r       <= AN_OFF;
            seg_r      <= SEG_BLANK;
            pending_r  <= 1'b0;
            frame_r    <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_r[i]  <= 4'hF;
                display_r[i] <= 4'hF;
            end
        end else if (!en_i) begin
            state_r    <= ST_BLANK;
            digit_r    <= 2'd0;
            div_cnt_r  <= '0;
            slot_cnt_r <= '0;
            an_r       <= AN_OFF;
            seg_r      <= SEG_BLANK;
            frame_r    <= 1'b0;
            // Nothing is being scanned, so a load goes straight to display.
            if (load_i) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    shadow_r[i]  <= x_s[i];
                    display_r[i] <= x_s[i];
                end
                pending_r <= 1'b0;
            end
        end else begin
            frame_r   <= 1'b0;
            div_cnt_r <= tick_s ? '0 : div_cnt_r + DIV_W'(1);
            if (load_i) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    shadow_r[i] <= x_s[i];
                end
                pending_r <= 1'b1;
            end
            if (tick_s) begin
                case (state_r)
                    ST_BLANK: begin
                        if (slot_cnt_r == SLOT_W'(BLANK_TICKS - 1)) begin
                            state_r    <= ST_SHOW;
                            slot_cnt_r <= '0;
                            an_r       <= an_sel(digit_r);
                            seg_r      <= dec_out_s;
                        end else begin
                            slot_cnt_r <= slot_cnt_r + SLOT_W'(1);
                        end
                    end
                    ST_SHOW: begin
                        if (slot_cnt_r == SLOT_W'(SHOW_TICKS - 1)) begin
                            state_r    <= ST_BLANK;
                            slot_cnt_r <= '0;
                            digit_r    <= digit_r + 2'd1;
                            an_r       <= AN_OFF;
                            seg_r      <= SEG_BLANK;
                            // Frame boundary: swap buffers. A load landing on
                            // this edge bypasses the shadow and overrides the
                            // pending flag set above.
                            if (digit_r == 2'd3) begin
                                frame_r <= 1'b1;
                                if (load_i) begin
                                    for (int i = 0; i < NUM_DIGITS; i++) begin
                                        display_r[i] <= x_s[i];
                                    end
                                    pending_r <= 1'b0;
                                end else if (pending_r) begin
                                    for (int i = 0; i < NUM_DIGITS; i++) begin
                                        display_r[i] <= shadow_r[i];
                                    end
                                    pending_r <= 1'b0;
                                end else begin
                                    pending_r <= pending_r;
                                end
                            end
                        end else begin
                            slot_cnt_r <= slot_cnt_r + SLOT_W'(1);
                        end
                    end
                    default: begin
                        state_r    <= ST_BLANK;
                        slot_cnt_r <= '0;
                    end
                endcase
            end
        end
    end

    assign an_o      = an_r;
    assign seg_o     = seg_r;
    assign pending_o = pending_r;
    assign frame_o   = frame_r;

endmodule
